// File: rtl/systolic_skew_feeder.sv
// Diagonal skew feeder for the systolic array edge: lane i is delayed by i
// cycles relative to lane 0, with handshake, stall, flush and drain status.
module systolic_skew_feeder #(
  parameter int ARR_SIZE = 4,
  parameter int DATA_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ARR_SIZE*DATA_W-1:0] in_data,
  input  logic                       stall,
  input  logic                       flush,
  output logic [ARR_SIZE*DATA_W-1:0] out_data,
  output logic [ARR_SIZE-1:0]        out_valid,
  output logic                       busy,
  output logic                       drain_done,
  output logic [15:0]                beat_count
);

  logic                acc;
  logic [ARR_SIZE-1:0] lane_busy;
  logic [ARR_SIZE-1:0] lane_busy_d;
  logic                drain_q;
  logic [15:0]         beat_q;

  assign in_ready = rst & ~stall & ~flush;
  assign acc      = in_valid & in_ready;

  for (genvar i = 0; i < ARR_SIZE; i++) begin : g_lane
    logic [DATA_W-1:0] d_q [i+1];
    logic [DATA_W-1:0] d_d [i+1];
    logic [i:0]        v_q;
    logic [i:0]        v_d;

    // Next state assumes the chain advances; the register decides whether to take it.
    always_comb begin
      v_d    = v_q;
      v_d[0] = acc;
      d_d[0] = acc ? in_data[i*DATA_W +: DATA_W] : '0;
      for (int j = 1; j <= i; j++) begin
        v_d[j] = v_q[j-1];
        d_d[j] = d_q[j-1];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_q <= '0;
        for (int j = 0; j <= i; j++) d_q[j] <= '0;
      end else if (flush) begin
        v_q <= '0;
        for (int j = 0; j <= i; j++) d_q[j] <= '0;
      end else if (!stall) begin
        v_q <= v_d;
        for (int j = 0; j <= i; j++) d_q[j] <= d_d[j];
      end
    end

    assign out_data[i*DATA_W +: DATA_W] = d_q[i];
    assign out_valid[i]                 = v_q[i];
    assign lane_busy[i]                 = |v_q;
    assign lane_busy_d[i]               = |v_d;
  end

  assign busy = |lane_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drain_q <= 1'b0;
      beat_q  <= '0;
    end else if (flush) begin
      drain_q <= 1'b0;
      beat_q  <= '0;
    end else if (stall) begin
      drain_q <= 1'b0;
    end else begin
      drain_q <= busy & ~(|lane_busy_d);
      if (acc && beat_q != 16'hFFFF)
        beat_q <= beat_q + 16'd1;
    end
  end

  assign drain_done = drain_q;
  assign beat_count = beat_q;

endmodule
